// File: rtl/bus_pkg.sv
// Shared definitions for the memory-mapped bus initiator: state encoding,
// bus mode values and default widths.
package bus_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RACK  = 2'd3
  } bus_state_e;

  localparam logic BUS_MODE_READ  = 1'b0;
  localparam logic BUS_MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Cycle counter for the bus timeout: cleared when a transaction starts,
// counts while it waits, flags the last allowed waiting cycle.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == LAST);

endmodule

// File: rtl/bus_master.sv
// Bus initiator: turns one CPU load/store into a single bus transaction,
// with a timeout that closes accesses no slave answers.
module bus_master
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] BUS_addr,
  output logic [DATA_WIDTH-1:0] BUS_wdata,
  input  logic [DATA_WIDTH-1:0] BUS_rdata,
  output logic                  BUS_valid,
  output logic                  BUS_mode,
  input  logic                  BUS_wready,
  input  logic                  BUS_rvalid,
  output logic                  BUS_rready
);

  bus_state_e            r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_bus_addr, w_bus_addr_next;
  logic [DATA_WIDTH-1:0] r_bus_wdata, w_bus_wdata_next;
  logic                  r_bus_valid, w_bus_valid_next;
  logic                  r_bus_mode, w_bus_mode_next;
  logic                  r_bus_rready, w_bus_rready_next;
  logic                  r_cpu_busy, w_cpu_busy_next;
  logic                  r_cpu_done, w_cpu_done_next;
  logic                  r_cpu_err, w_cpu_err_next;
  logic [DATA_WIDTH-1:0] r_cpu_rdata, w_cpu_rdata_next;
  logic                  w_cnt_clear, w_cnt_en, w_expire;

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_cnt_clear),
    .i_enable(w_cnt_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_valid  <= 1'b0;
      r_bus_mode   <= 1'b0;
      r_bus_rready <= 1'b0;
      r_cpu_busy   <= 1'b0;
      r_cpu_done   <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_bus_addr   <= w_bus_addr_next;
      r_bus_wdata  <= w_bus_wdata_next;
      r_bus_valid  <= w_bus_valid_next;
      r_bus_mode   <= w_bus_mode_next;
      r_bus_rready <= w_bus_rready_next;
      r_cpu_busy   <= w_cpu_busy_next;
      r_cpu_done   <= w_cpu_done_next;
      r_cpu_err    <= w_cpu_err_next;
      r_cpu_rdata  <= w_cpu_rdata_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_bus_addr_next   = r_bus_addr;
    w_bus_wdata_next  = r_bus_wdata;
    w_bus_valid_next  = r_bus_valid;
    w_bus_mode_next   = r_bus_mode;
    w_bus_rready_next = r_bus_rready;
    w_cpu_busy_next   = r_cpu_busy;
    w_cpu_rdata_next  = r_cpu_rdata;
    w_cpu_done_next   = 1'b0;
    w_cpu_err_next    = 1'b0;
    w_cnt_clear       = 1'b0;
    w_cnt_en          = 1'b0;

    case (r_state)
      IDLE: begin
        w_bus_valid_next  = 1'b0;
        w_bus_rready_next = 1'b0;
        w_cpu_busy_next   = 1'b0;
        if (cpu_req) begin
          w_bus_addr_next  = cpu_addr;
          w_bus_wdata_next = cpu_wdata;
          w_bus_mode_next  = cpu_we ? BUS_MODE_WRITE : BUS_MODE_READ;
          w_bus_valid_next = 1'b1;
          w_cpu_busy_next  = 1'b1;
          w_cnt_clear      = 1'b1;
          w_state_next     = cpu_we ? WRITE : READ;
        end
      end

      // A response on the expiry edge takes priority over the timeout.
      WRITE: begin
        if (BUS_wready) begin
          w_bus_valid_next = 1'b0;
          w_cpu_busy_next  = 1'b0;
          w_cpu_done_next  = 1'b1;
          w_state_next     = IDLE;
        end else if (w_expire) begin
          w_bus_valid_next = 1'b0;
          w_cpu_busy_next  = 1'b0;
          w_cpu_done_next  = 1'b1;
          w_cpu_err_next   = 1'b1;
          w_state_next     = IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end

      READ: begin
        if (BUS_rvalid) begin
          w_cpu_rdata_next  = BUS_rdata;
          w_bus_rready_next = 1'b1;
          w_cpu_done_next   = 1'b1;
          w_state_next      = RACK;
        end else if (w_expire) begin
          w_cpu_rdata_next = '0;
          w_bus_valid_next = 1'b0;
          w_cpu_busy_next  = 1'b0;
          w_cpu_done_next  = 1'b1;
          w_cpu_err_next   = 1'b1;
          w_state_next     = IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end

      RACK: begin
        w_bus_valid_next  = 1'b0;
        w_bus_rready_next = 1'b0;
        w_cpu_busy_next   = 1'b0;
        w_state_next      = IDLE;
      end

      default: w_state_next = IDLE;
    endcase
  end

  assign cpu_busy   = r_cpu_busy;
  assign cpu_done   = r_cpu_done;
  assign cpu_err    = r_cpu_err;
  assign cpu_rdata  = r_cpu_rdata;
  assign BUS_addr   = r_bus_addr;
  assign BUS_wdata  = r_bus_wdata;
  assign BUS_valid  = r_bus_valid;
  assign BUS_mode   = r_bus_mode;
  assign BUS_rready = r_bus_rready;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: a slave model over 0x0001_0000..0x0001_FFFF with
// programmable latency, a completion scoreboard and a vector table.
module tb_bus_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_busy, cpu_done, cpu_err;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] BUS_addr;
  logic [DW-1:0] BUS_wdata;
  logic [DW-1:0] BUS_rdata;
  logic          BUS_valid, BUS_mode, BUS_rready;
  logic          BUS_wready, BUS_rvalid;

  always #5 clk = ~clk;

  bus_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata), .BUS_rdata(BUS_rdata),
    .BUS_valid(BUS_valid), .BUS_mode(BUS_mode),
    .BUS_wready(BUS_wready), .BUS_rvalid(BUS_rvalid), .BUS_rready(BUS_rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  typedef enum {SL_IDLE, SL_WAIT, SL_RESP_R, SL_RESP_W} sl_state_e;
  sl_state_e   sl_state;
  logic [31:0] sl_mem [16];
  int          sl_cnt;
  int          sl_writes = 0;
  int          sl_reads = 0;
  int          slave_lat = 0;

  function automatic bit sl_hit(input logic [31:0] a);
    return a[31:16] == 16'h0001;
  endfunction

  // Response becomes visible slave_lat+2 edges after BUS_valid rises.
  always @(posedge clk) begin
    if (!rst_n) begin
      sl_state   <= SL_IDLE;
      BUS_wready <= 1'b0;
      BUS_rvalid <= 1'b0;
      BUS_rdata  <= '0;
      sl_cnt     <= 0;
      for (int i = 0; i < 16; i++) sl_mem[i] <= (i == 1) ? 32'h1234_5678 : 32'h0;
    end else begin
      case (sl_state)
        SL_IDLE: if (BUS_valid && sl_hit(BUS_addr)) begin
          sl_cnt   <= slave_lat;
          sl_state <= SL_WAIT;
        end
        SL_WAIT: begin
          if (!BUS_valid) sl_state <= SL_IDLE;
          else if (sl_cnt == 0) begin
            if (BUS_mode) begin
              sl_mem[BUS_addr[5:2]] <= BUS_wdata;
              BUS_wready <= 1'b1;
              sl_writes  <= sl_writes + 1;
              sl_state   <= SL_RESP_W;
            end else begin
              BUS_rdata  <= sl_mem[BUS_addr[5:2]];
              BUS_rvalid <= 1'b1;
              sl_state   <= SL_RESP_R;
            end
          end else sl_cnt <= sl_cnt - 1;
        end
        SL_RESP_W: begin
          BUS_wready <= 1'b0;
          sl_state   <= SL_IDLE;
        end
        SL_RESP_R: begin
          if (!BUS_valid) begin
            BUS_rvalid <= 1'b0;
            sl_state   <= SL_IDLE;
          end else if (BUS_rready) begin
            BUS_rvalid <= 1'b0;
            sl_reads   <= sl_reads + 1;
            sl_state   <= SL_IDLE;
          end
        end
        default: sl_state <= SL_IDLE;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   gap = 0;
  int   done_cnt = 0;
  int   rready_cycles = 0;
  int   rready_viol = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (BUS_rready === 1'b1) begin
      rready_cycles++;
      if (BUS_rvalid !== 1'b1) rready_viol++;
    end
    if (BUS_valid === 1'b1 && !prev_valid) begin
      gap = cyc - fall_cyc;
      rise_cyc = cyc;
    end
    if (BUS_valid === 1'b0 && prev_valid) fall_cyc = cyc;
    prev_valid = (BUS_valid === 1'b1);
    if (cpu_done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("done_err", cpu_err, e.err);
        chk("done_rdata", cpu_rdata, e.rdata);
        chk("done_latency", cyc - rise_cyc, e.lat);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_lat;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] model_rdata = '0;
  int          exp_writes = 0;
  int          exp_reads = 0;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, input logic err, input logic [31:0] rdata, input int elat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.lat = 8'(lat);
    v.exp_err = err; v.exp_rdata = rdata; v.exp_lat = 8'(elat);
    return v;
  endfunction

  // Push the expectation for one request and update the bench-side model.
  task automatic expect_txn(input logic we, input logic err, input logic [31:0] rdata, input int lat);
    exp_t e;
    e.err = err;
    e.lat = 8'(lat);
    if (!we) model_rdata = err ? 32'h0 : rdata;
    e.rdata = model_rdata;
    if (!err) begin
      if (we) exp_writes++;
      else exp_reads++;
    end
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout: got %0d pending expected 0 pending", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic post_checks(input logic exp_rready);
    @(negedge clk);
    chk("valid_low_after", BUS_valid, 0);
    chk("rready_cycles", rready_cycles, exp_rready ? 1 : 0);
    chk("slave_writes", sl_writes, exp_writes);
    chk("slave_reads", sl_reads, exp_reads);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    rready_cycles = 0;
    expect_txn(v.we, v.exp_err, v.exp_rdata, int'(v.exp_lat));
    slave_lat = int'(v.lat);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    wait_done(tag);
    $display("txn %s we=%0d addr=%08h wdata=%08h lat=%0d -> err=%0d rdata=%08h",
             tag, v.we, v.addr, v.wdata, v.lat, cpu_err, cpu_rdata);
    post_checks(!v.we && !v.exp_err);
  endtask

  initial begin
    int moved;
    int dbefore;
    int done0;
    vecs[0]  = mk(1, 32'h0001_0010, 32'hDEAD_BEEF, 0,  0, 32'h0,         3);
    vecs[1]  = mk(0, 32'h0001_0010, 32'h0,         2,  0, 32'hDEAD_BEEF, 5);
    vecs[2]  = mk(0, 32'h0001_0004, 32'h0,         0,  0, 32'h1234_5678, 3);
    vecs[3]  = mk(1, 32'h0001_0020, 32'h0BAD_F00D, 3,  0, 32'h0,         6);
    vecs[4]  = mk(0, 32'h0001_0020, 32'h0,         1,  0, 32'h0BAD_F00D, 4);
    vecs[5]  = mk(1, 32'h0000_0008, 32'h1111_1111, 0,  1, 32'h0,         16);
    vecs[6]  = mk(0, 32'h0000_0004, 32'h0,         0,  1, 32'h0,         16);
    vecs[7]  = mk(0, 32'h0001_0010, 32'h0,         13, 0, 32'hDEAD_BEEF, 16);
    vecs[8]  = mk(1, 32'h0001_0024, 32'h2222_2222, 13, 0, 32'h0,         16);
    vecs[9]  = mk(0, 32'h0001_0024, 32'h0,         14, 1, 32'h0,         16);
    vecs[10] = mk(0, 32'h0001_0024, 32'h0,         0,  0, 32'h2222_2222, 3);
    vecs[11] = mk(1, 32'h0001_FFFC, 32'h5A5A_0F0F, 1,  0, 32'h0,         4);
    vecs[12] = mk(0, 32'h0001_FFFC, 32'h0,         0,  0, 32'h5A5A_0F0F, 3);
    vecs[13] = mk(0, 32'h0002_0000, 32'h0,         0,  1, 32'h0,         16);
    vecs[14] = mk(1, 32'h0001_0000, 32'hCAFE_F00D, 0,  0, 32'h0,         3);
    vecs[15] = mk(0, 32'h0001_0000, 32'h0,         2,  0, 32'hCAFE_F00D, 5);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {cpu_busy, cpu_done, cpu_err, BUS_valid, BUS_mode, BUS_rready}, 0);
    chk("reset_rdata", cpu_rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: request held high across a write and a read of the same word.
    rready_cycles = 0;
    done0 = done_cnt;
    expect_txn(1'b1, 1'b0, 32'h0, 3);
    expect_txn(1'b0, 1'b0, 32'hA5A5_A5A5, 3);
    slave_lat = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0001_0030; cpu_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (BUS_valid && BUS_mode == 1'b0) break;
    end
    cpu_req = 1'b0;
    wait_done("b2b");
    $display("txn b2b write+read addr=00010030 -> rdata=%08h gap=%0d", cpu_rdata, gap);
    chk("b2b_valid_gap", (gap >= 1), 1);
    chk("b2b_done_pulses", done_cnt - done0, 2);
    post_checks(1'b1);

    // Request with a different address while a read is pending.
    rready_cycles = 0;
    expect_txn(1'b0, 1'b0, 32'h1234_5678, 8);
    slave_lat = 5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_0004;
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 32'h0001_0020; cpu_wdata = 32'hFFFF_0000;
    moved = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (BUS_addr !== 32'h0001_0004 || BUS_mode !== 1'b0) moved++;
    end
    cpu_req = 1'b0;
    wait_done("busy");
    $display("txn busy_ignore addr=00010004 -> rdata=%08h", cpu_rdata);
    chk("busy_addr_stable", moved, 0);
    post_checks(1'b1);

    // Asynchronous reset while a read to an unmapped address is pending.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_valid", BUS_valid, 1);
    chk("pre_reset_rdata", cpu_rdata, 32'h1234_5678);
    dbefore = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {cpu_busy, cpu_done, cpu_err, BUS_valid, BUS_mode, BUS_rready}, 0);
    chk("midreset_rdata", cpu_rdata, 0);
    chk("midreset_addr", BUS_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("txn reset_abort addr=00000100 -> done_pulses=%0d", done_cnt - dbefore);
    chk("no_done_after_abort", done_cnt - dbefore, 0);
    model_rdata = 32'h0;

    for (int i = 14; i < 16; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    chk("rready_only_with_rvalid", rready_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
